// File: rtl/regfile_wbq_if.sv
`default_nettype none
// +------------------------------------------------------------------+
// | regfile_wbq_if : producer, drain and forwarding signals          |
// | Revision 1.0                                                     |
// +------------------------------------------------------------------+
interface regfile_wbq_if #(
  parameter int WIDTH   = 32,
  parameter int REGBITS = 3,
  parameter int DEPTH   = 4
) ();
  localparam int CW = $clog2(DEPTH) + 1;

  logic               req_valid_i;
  logic [REGBITS-1:0] req_addr_i;
  logic [WIDTH-1:0]   req_data_i;
  logic               req_ready_o;
  logic               wb_en_i;
  logic               regwrite_o;
  logic [REGBITS-1:0] wa_o;
  logic [WIDTH-1:0]   wd_o;
  logic [REGBITS-1:0] fwd_ra_i;
  logic               fwd_hit_o;
  logic [WIDTH-1:0]   fwd_data_o;
  logic [CW-1:0]      count_o;

  modport master (
    output req_valid_i, req_addr_i, req_data_i, wb_en_i, fwd_ra_i,
    input  req_ready_o, regwrite_o, wa_o, wd_o, fwd_hit_o, fwd_data_o, count_o
  );

  modport slave (
    input  req_valid_i, req_addr_i, req_data_i, wb_en_i, fwd_ra_i,
    output req_ready_o, regwrite_o, wa_o, wd_o, fwd_hit_o, fwd_data_o, count_o
  );
endinterface
`default_nettype wire

// File: rtl/regfile_wbq.sv
`default_nettype none
// +------------------------------------------------------------------+
// | regfile_wbq : write-back FIFO in front of the register file      |
// | write port, with youngest-entry forwarding lookup                |
// | Revision 1.0                                                     |
// +------------------------------------------------------------------+
module regfile_wbq #(
  parameter int WIDTH   = 32,
  parameter int REGBITS = 3,
  parameter int DEPTH   = 4
) (
  input  logic          clk,
  input  logic          rst_n_i,
  regfile_wbq_if.slave  bus
);
  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;

  logic [REGBITS-1:0] r_addr [DEPTH];
  logic [WIDTH-1:0]   r_data [DEPTH];
  logic [DEPTH-1:0]   r_valid;
  logic [PW-1:0]      r_head;
  logic [PW-1:0]      r_tail;
  logic [CW-1:0]      r_count;

  logic               w_full;
  logic               w_empty;
  logic               w_push;
  logic               w_pop;
  logic               w_hit;
  logic [WIDTH-1:0]   w_fdata;

  assign w_full  = (r_count == CW'(DEPTH));
  assign w_empty = (r_count == '0);
  assign w_pop   = bus.wb_en_i && !w_empty;
  // Address-0 requests complete the handshake but never occupy an entry.
  assign w_push  = bus.req_valid_i && bus.req_ready_o && (bus.req_addr_i != '0);

  assign bus.req_ready_o = rst_n_i && !w_full;
  assign bus.regwrite_o  = w_pop;
  assign bus.wa_o        = w_empty ? '0 : r_addr[r_head];
  assign bus.wd_o        = w_empty ? '0 : r_data[r_head];
  assign bus.count_o     = r_count;
  assign bus.fwd_hit_o   = w_hit;
  assign bus.fwd_data_o  = w_fdata;

  // Walk oldest to youngest so the last match (closest to tail) wins.
  always_comb begin
    logic [PW-1:0] idx;
    w_hit   = 1'b0;
    w_fdata = '0;
    idx     = '0;
    for (int i = 0; i < DEPTH; i++) begin
      idx = r_head + PW'(i);
      if (r_valid[idx] && (r_addr[idx] == bus.fwd_ra_i) && (bus.fwd_ra_i != '0)) begin
        w_hit   = 1'b1;
        w_fdata = r_data[idx];
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n_i) begin
    if (!rst_n_i) begin
      r_head  <= '0;
      r_tail  <= '0;
      r_count <= '0;
      r_valid <= '0;
    end else begin
      if (w_push) begin
        r_valid[r_tail] <= 1'b1;
        r_tail          <= r_tail + PW'(1);
      end
      if (w_pop) begin
        r_valid[r_head] <= 1'b0;
        r_head          <= r_head + PW'(1);
      end
      r_count <= r_count + CW'(w_push) - CW'(w_pop);
    end
  end

  // Payload storage is qualified by r_valid, so it needs no reset.
  always_ff @(posedge clk) begin
    if (w_push) begin
      r_addr[r_tail] <= bus.req_addr_i;
      r_data[r_tail] <= bus.req_data_i;
    end
  end
endmodule
`default_nettype wire

// File: doc/regfile_wbq.md
# regfile_wbq

Write-back queue that sits in front of the register file's single write port and is the producer side of that interface. Execution units hand completed results (destination register and value) into a small FIFO through a valid/ready handshake. The block drains one entry per cycle into the register file's write port (`regwrite`, `wa`, `wd`) whenever draining is enabled. Because queued results are not yet architecturally visible, it also provides a forwarding lookup that returns the youngest pending value for a queried register.

## Interface
- `WIDTH`, 32: data width, matches register file word width.
- `REGBITS`, 3: register address width; 2^REGBITS registers; register 0 is hard-wired zero.
- `DEPTH`, 4: queue entries; power of two, ≥ 2.

- `clk`  in  1  clock, all state updates on rising edge.
- `rst_n_i`  in  1  reset, asynchronous, active-low.
- `req_valid_i`  in  1  producer has a result.
- `req_addr_i`  in  REGBITS  destination register.
- `req_data_i`  in  WIDTH  result value.
- `req_ready_o`  out  1  queue can accept this cycle.
- `wb_en_i`  in  1  register file write port available this cycle.
- `regwrite_o`  out  1  write strobe to register file.
- `wa_o`  out  REGBITS  write address to register file.
- `wd_o`  out  WIDTH  write data to register file.
- `fwd_ra_i`  in  REGBITS  forwarding lookup address.
- `fwd_hit_o`  out  1  a pending entry targets `fwd_ra_i`.
- `fwd_data_o`  out  WIDTH  youngest pending value for `fwd_ra_i`.
- `count_o`  out  log2(DEPTH)+1  number of occupied entries.

## Operation
- Storage: DEPTH entries of {addr, data, valid}, head/tail pointers wrapping modulo DEPTH, occupancy counter 0..DEPTH.
- Accept: `req_valid_i && req_ready_o` at a rising edge.
  - `req_addr_i != 0`: entry written at tail, tail advances, valid set.
  - `req_addr_i == 0`: request consumed (handshake completes) but nothing is enqueued.
- `req_ready_o = rst_n_i && (count != DEPTH)`. No same-cycle pass-through when full; a pop in the same cycle does not raise ready.
- Drain: `regwrite_o = wb_en_i && (count != 0)`. `wa_o`/`wd_o` present the head entry; they are 0 when the queue is empty. On a rising edge with `regwrite_o` high, the head entry is invalidated and the head pointer advances. The register file captures the write on that same edge.
- Simultaneous push and pop: both occur; count is unchanged. When full, the pop still occurs and the push is refused (ready is low).
- Order: entries retire strictly in acceptance order. Multiple pending writes to one register are all retired, so the last one wins.
- Forwarding: combinational over valid entries, including the head being written this cycle.
  - `fwd_hit_o = (fwd_ra_i != 0) && any valid entry with matching addr`.
  - `fwd_data_o` = data of the youngest matching entry (closest to tail), else 0.
  - A request being accepted in the same cycle is not visible until the next cycle.
- `count_o` reflects registered occupancy.

## Timing
- Reset (`rst_n_i` low, takes effect immediately): count 0, head/tail 0, all valid bits 0. Outputs: `req_ready_o` 0, `regwrite_o` 0, `wa_o` 0, `wd_o` 0, `fwd_hit_o` 0, `fwd_data_o` 0, `count_o` 0.
- Reset asserted mid-operation discards all pending entries with no write issued; the register file retains prior contents.
- After reset release, `req_ready_o` is 1 in the first cycle.
- Latency: a request accepted at edge N is at the head (if the queue was empty) and drives `regwrite_o` during cycle N+1 provided `wb_en_i`=1. It is architecturally written at edge N+1.
- Throughput: one accept and one retire per cycle sustained.
- `wb_en_i` low holds the queue. Outputs `wa_o`/`wd_o` stay at the head entry; `regwrite_o` is 0.
- Pointer wrap from DEPTH-1 to 0 is seamless; no bubble.

## Test plan
- Reset then single push {addr 3, data 0xDEADBEEF} with `wb_en_i`=1 -> `count_o`=1 next cycle. `regwrite_o`=1, `wa_o`=3, `wd_o`=0xDEADBEEF for exactly one cycle, then `count_o`=0.
- Fill with `wb_en_i`=0: push 4 entries to addrs 1,2,3,4 -> `req_ready_o`=0, `count_o`=4, fifth request held. Raise `wb_en_i` -> writes retire in order 1,2,3,4 over 4 cycles, and the fifth is accepted the cycle after the first pop.
- Forwarding: with `wb_en_i`=0, push {5, 0x11} then {5, 0x22}; `fwd_ra_i`=5 -> `fwd_hit_o`=1, `fwd_data_o`=0x22. `fwd_ra_i`=0 or 6 -> hit 0, data 0.
- Addr-0 request {0, 0xFFFF} -> `req_ready_o`=1 handshake completes, `count_o` unchanged, no `regwrite_o`.
- Streaming: continuous push and `wb_en_i`=1 for 10 cycles with data 1..10 -> `count_o` steady at 1 and `wd_o` sequence 1..10 with no gaps across pointer wrap.
- Reset asserted asynchronously with 3 pending entries -> all outputs 0 immediately; after release `count_o`=0 and no stale write appears.
